// File: rtl/cpu_clock_ctrl.sv
// Clock-enable controller for the CPU core: issues single-cycle cpu_ce pulses at a
// programmable rate (RUN), once per debounced button press (STEP), or never (HALT).
module cpu_clock_ctrl #(
    parameter int DIV_W    = 21,
    parameter int DEF_DIV  = 250000,
    parameter int DB_W     = 20,
    parameter int DB_COUNT = 500000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mode_run_i,
    input  logic             step_btn_i,
    input  logic             halt_req_i,
    input  logic             div_wr_i,
    input  logic [DIV_W-1:0] div_data_i,
    output logic             cpu_ce_o,
    output logic             cpu_clock_o,
    output logic [1:0]       state_o,
    output logic [15:0]      tick_count_o
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);
    localparam logic [DB_W-1:0]  DbLast = DB_W'(DB_COUNT - 1);

    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_prev_q;
    logic             press;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             cpu_clock_q, cpu_clock_d;
    logic [15:0]      tick_count_q, tick_count_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            sync1_q    <= step_btn_i;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_db_q;
        end
    end

    // A level is accepted only after DB_COUNT consecutive cycles of disagreement.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign press = btn_db_q & ~btn_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HALT;
            cnt_q        <= '0;
            divisor_q    <= DefDiv;
            cpu_ce_q     <= 1'b0;
            cpu_clock_q  <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            divisor_q    <= divisor_d;
            cpu_ce_q     <= cpu_ce_d;
            cpu_clock_q  <= cpu_clock_d;
            tick_count_q <= tick_count_d;
        end
    end

    // halt_req outranks everything; a divisor write suppresses a terminal-count tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        cpu_ce_d  = 1'b0;

        if (div_wr_i) begin
            divisor_d = (div_data_i < MinDiv) ? MinDiv : div_data_i;
        end

        if (halt_req_i) begin
            state_d = HALT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HALT: begin
                    cnt_d = '0;
                    if (press) begin
                        state_d = mode_run_i ? RUN : STEP;
                    end
                end
                RUN: begin
                    if (!mode_run_i) begin
                        state_d = STEP;
                        cnt_d   = '0;
                    end else if (div_wr_i) begin
                        cnt_d = '0;
                    end else if (cnt_q == divisor_q - DIV_W'(1)) begin
                        cnt_d    = '0;
                        cpu_ce_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                STEP: begin
                    cnt_d = '0;
                    if (mode_run_i) begin
                        state_d = RUN;
                    end else if (press) begin
                        cpu_ce_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HALT;
                    cnt_d   = '0;
                end
            endcase
        end

        cpu_clock_d  = cpu_clock_q ^ cpu_ce_d;
        tick_count_d = cpu_ce_d ? tick_count_q + 16'd1 : tick_count_q;
    end

    assign cpu_ce_o     = cpu_ce_q;
    assign cpu_clock_o  = cpu_clock_q;
    assign state_o      = state_q;
    assign tick_count_o = tick_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed testbench for cpu_clock_ctrl with short debounce (8) and default divisor (6).
module tb_cpu_clock_ctrl;

    localparam int DIV_W = 21;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode_run;
    logic             step_btn;
    logic             halt_req;
    logic             div_wr;
    logic [DIV_W-1:0] div_data;
    logic             cpu_ce;
    logic             cpu_clock;
    logic [1:0]       state;
    logic [15:0]      tick_count;

    int checks = 0;
    int errors = 0;
    int ceSeen = 0;

    cpu_clock_ctrl #(
        .DIV_W   (DIV_W),
        .DEF_DIV (6),
        .DB_W    (20),
        .DB_COUNT(8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_run_i  (mode_run),
        .step_btn_i  (step_btn),
        .halt_req_i  (halt_req),
        .div_wr_i    (div_wr),
        .div_data_i  (div_data),
        .cpu_ce_o    (cpu_ce),
        .cpu_clock_o (cpu_clock),
        .state_o     (state),
        .tick_count_o(tick_count)
    );

    always #5 clk = ~clk;

    // Reference tick counter: counts every cpu_ce pulse seen shortly after each edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ceSeen = 0;
        end else if (cpu_ce) begin
            ceSeen = ceSeen + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic btn, input logic halt,
                                 input logic wr, input logic [DIV_W-1:0] data);
        mode_run = mr;
        step_btn = btn;
        halt_req = halt;
        div_wr   = wr;
        div_data = data;
    endtask

    // Expects cpu_ce low for n-1 cycles and high on the n-th.
    task automatic expectCePattern(input string tag, input int n);
        int early;
        early = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i < n && cpu_ce) early++;
        end
        checkOutput({tag, "_early"}, early, 0);
        checkOutput({tag, "_ce"}, {31'd0, cpu_ce}, 1);
    endtask

    task automatic countCe(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cpu_ce) cnt++;
        end
    endtask

    task automatic waitForCe(input string tag, input int maxCycles);
        int found;
        found = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (cpu_ce) begin
                found = 1;
                break;
            end
        end
        checkOutput({tag, "_seen"}, found, 1);
    endtask

    // Raw button held high long enough for sync (2) + debounce (8) + issue (1).
    task automatic pressAndWait();
        step_btn = 1'b1;
        repeat (11) @(negedge clk);
        step_btn = 1'b0;
    endtask

    initial begin
        int cnt;
        int pos;
        int found;

        // Reset held while inputs are exercised
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 21'd3);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 21'd0);
        repeat (15) @(negedge clk);
        checkOutput("rst_state", {30'd0, state}, 0);
        checkOutput("rst_ce", {31'd0, cpu_ce}, 0);
        checkOutput("rst_clock", {31'd0, cpu_clock}, 0);
        checkOutput("rst_ticks", {16'd0, tick_count}, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 21'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countCe(20, cnt);
        checkOutput("post_rst_no_ce", cnt, 0);
        checkOutput("post_rst_state", {30'd0, state}, 0);

        // RUN at default divisor, then 4, then clamped 0 -> 2
        mode_run = 1'b1;
        pressAndWait();
        checkOutput("resume_state", {30'd0, state}, 1);
        checkOutput("resume_no_tick", {31'd0, cpu_ce}, 0);
        expectCePattern("def_div_first", 6);
        expectCePattern("def_div_period", 6);
        checkOutput("def_div_phase", {31'd0, cpu_clock}, ceSeen[0]);

        div_wr   = 1'b1;
        div_data = 21'd4;
        @(negedge clk);
        div_wr   = 1'b0;
        expectCePattern("div4_first", 4);
        checkOutput("div4_phase_a", {31'd0, cpu_clock}, ceSeen[0]);
        expectCePattern("div4_period_a", 4);
        checkOutput("div4_phase_b", {31'd0, cpu_clock}, ceSeen[0]);
        expectCePattern("div4_period_b", 4);

        div_wr   = 1'b1;
        div_data = 21'd0;
        @(negedge clk);
        div_wr   = 1'b0;
        expectCePattern("div2_first", 2);
        expectCePattern("div2_period", 2);
        checkOutput("div2_phase", {31'd0, cpu_clock}, ceSeen[0]);
        checkOutput("run_ticks", {16'd0, tick_count}, {16'd0, ceSeen[15:0]});

        // Debounce in STEP: bouncing button then stable press
        mode_run = 1'b0;
        @(negedge clk);
        checkOutput("to_step_state", {30'd0, state}, 2);
        cnt = 0;
        pos = 0;
        for (int i = 0; i < 40; i++) begin
            step_btn = ((i % 6) < 3);
            @(negedge clk);
            if (cpu_ce) cnt++;
        end
        step_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cpu_ce) begin
                cnt++;
                pos = k;
            end
        end
        checkOutput("db_ce_count", cnt, 1);
        checkOutput("db_ce_latency", pos, 11);
        step_btn = 1'b0;
        countCe(15, cnt);
        checkOutput("db_release_no_ce", cnt, 0);
        checkOutput("db_ticks", {16'd0, tick_count}, {16'd0, ceSeen[15:0]});

        // Halt on terminal count, then resume
        mode_run = 1'b1;
        div_wr   = 1'b1;
        div_data = 21'd4;
        @(negedge clk);
        div_wr   = 1'b0;
        checkOutput("step_to_run_state", {30'd0, state}, 1);
        repeat (3) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checkOutput("halt_state", {30'd0, state}, 0);
        checkOutput("halt_no_tick", {31'd0, cpu_ce}, 0);
        countCe(10, cnt);
        checkOutput("halt_quiet", cnt, 0);
        pressAndWait();
        checkOutput("halt_resume_state", {30'd0, state}, 1);
        expectCePattern("halt_resume_first", 4);

        // Mode switch in STEP coinciding with a press
        mode_run = 1'b0;
        @(negedge clk);
        checkOutput("run_to_step_state", {30'd0, state}, 2);
        repeat (15) @(negedge clk);
        step_btn = 1'b1;
        repeat (10) @(negedge clk);
        mode_run = 1'b1;
        @(negedge clk);
        checkOutput("switch_state", {30'd0, state}, 1);
        checkOutput("switch_no_tick", {31'd0, cpu_ce}, 0);
        mode_run = 1'b0;
        step_btn = 1'b0;
        @(negedge clk);
        checkOutput("switch_back_state", {30'd0, state}, 2);
        checkOutput("switch_back_cnt", {11'd0, dut.cnt_q}, 0);
        checkOutput("switch_back_no_ce", {31'd0, cpu_ce}, 0);
        repeat (15) @(negedge clk);

        // Tick counter wrap from a preloaded value near the top
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        force dut.tick_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.tick_count_q;
        mode_run = 1'b1;
        pressAndWait();
        waitForCe("wrap_first", 10);
        checkOutput("wrap_ffff", {16'd0, tick_count}, 32'h0000FFFF);
        waitForCe("wrap_second", 10);
        checkOutput("wrap_zero", {16'd0, tick_count}, 0);

        // Asynchronous reset mid-RUN while cpu_ce and cpu_clock are both high
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ce && cpu_clock) begin
                found = 1;
                break;
            end
        end
        checkOutput("pre_rst_high_seen", found, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ce", {31'd0, cpu_ce}, 0);
        checkOutput("async_rst_clock", {31'd0, cpu_clock}, 0);
        checkOutput("async_rst_state", {30'd0, state}, 0);
        checkOutput("async_rst_ticks", {16'd0, tick_count}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        countCe(20, cnt);
        checkOutput("post_async_rst_no_ce", cnt, 0);
        checkOutput("post_async_rst_state", {30'd0, state}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
